// File: rtl/comparator_pkg.sv
// Shared result encoding and default widths for the stream comparator.
// Pure declarations, no logic or latency.
// No handshake of its own; users apply their own flow control.
package comparator_pkg;

    localparam int GT_BIT = 0;
    localparam int EQ_BIT = 1;
    localparam int LT_BIT = 2;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 16;

    typedef logic [2:0] cmp_result_t;

endpackage

// File: rtl/compare_core.sv
// One-hot magnitude compare of two operands, signed or unsigned.
// Purely combinational, zero cycles.
// No handshake; the enclosing pipeline decides when the result is used.
module compare_core
    import comparator_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output cmp_result_t      result
);

    logic aLess;

    always_comb begin
        aLess = signed_mode ? ($signed(a) < $signed(b)) : (a < b);
    end

    // Equality is tested first so it never depends on the mode.
    always_comb begin
        result = '0;
        if (a == b) begin
            result[EQ_BIT] = 1'b1;
        end else if (aLess) begin
            result[LT_BIT] = 1'b1;
        end else begin
            result[GT_BIT] = 1'b1;
        end
    end

endmodule

// File: rtl/stream_comparator.sv
// Two-stage valid/ready comparator with saturating per-result delivery counters.
// Latency 2 cycles from input transfer to oValid, throughput 1 per cycle.
// Backpressure: a stage advances when it is empty or its successor advances; oReady mirrors S1 advance.
module stream_comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SIGNED_EN = 1,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             iClk,
    input  logic             iRstN,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iDataA,
    input  logic [WIDTH-1:0] iDataB,
    input  logic             iSigned,
    output logic             oValid,
    input  logic             iReady,
    output logic [2:0]       oData,
    input  logic             iClear,
    output logic [CNT_W-1:0] oCntGt,
    output logic [CNT_W-1:0] oCntEq,
    output logic [CNT_W-1:0] oCntLt
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             signedMode;
    } s1_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic        s1Vld;
    s1_t         s1Dat;
    logic        s2Vld;
    cmp_result_t s2Dat;
    cmp_result_t coreRes;
    logic        s1Adv;
    logic        s2Adv;
    logic        outXfer;
    logic        effSigned;

    always_comb begin
        s2Adv     = !s2Vld || iReady;
        s1Adv     = !s1Vld || s2Adv;
        outXfer   = s2Vld && iReady;
        effSigned = iSigned && (SIGNED_EN != 0);
    end

    // Gated by reset so nothing is offered as accepted while held in reset.
    assign oReady = iRstN && s1Adv;
    assign oValid = s2Vld;
    assign oData  = s2Vld ? s2Dat : 3'b000;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            s1Vld <= 1'b0;
            s1Dat <= '0;
        end else if (s1Adv) begin
            s1Vld <= iValid;
            if (iValid) begin
                s1Dat <= '{a: iDataA, b: iDataB, signedMode: effSigned};
            end
        end
    end

    compare_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a           (s1Dat.a),
        .b           (s1Dat.b),
        .signed_mode (s1Dat.signedMode),
        .result      (coreRes)
    );

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            s2Vld <= 1'b0;
            s2Dat <= '0;
        end else if (s2Adv) begin
            s2Vld <= s1Vld;
            if (s1Vld) begin
                s2Dat <= coreRes;
            end
        end
    end

    // Clear has priority, so a coincident delivery is intentionally not counted.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            oCntGt <= '0;
            oCntEq <= '0;
            oCntLt <= '0;
        end else if (iClear) begin
            oCntGt <= '0;
            oCntEq <= '0;
            oCntLt <= '0;
        end else if (outXfer) begin
            if (s2Dat[GT_BIT] && (oCntGt != CNT_MAX)) begin
                oCntGt <= oCntGt + CNT_W'(1);
            end
            if (s2Dat[EQ_BIT] && (oCntEq != CNT_MAX)) begin
                oCntEq <= oCntEq + CNT_W'(1);
            end
            if (s2Dat[LT_BIT] && (oCntLt != CNT_MAX)) begin
                oCntLt <= oCntLt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_stream_comparator.sv
// Bench for stream_comparator: two 8-bit instances (signed enabled / disabled) on shared stimulus,
// checked each cycle against a transaction-level model plus directed literal expectations.
module tb_stream_comparator;

    localparam int W      = 8;
    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;

    logic          iClk    = 1'b0;
    logic          iRstN   = 1'b0;
    logic          iValid  = 1'b0;
    logic          iReady  = 1'b1;
    logic          iSigned = 1'b0;
    logic          iClear  = 1'b0;
    logic [W-1:0]  iDataA  = '0;
    logic [W-1:0]  iDataB  = '0;

    logic          oReady0, oValid0, oReady1, oValid1;
    logic [2:0]    oData0, oData1;
    logic [CW-1:0] gt0, eq0, lt0, gt1, eq1, lt1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int nOut   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sgn;
        int           acc;
    } item_t;

    item_t fifo[$];
    int    mCnt[2][3];

    stream_comparator #(.WIDTH(W), .SIGNED_EN(1), .CNT_W(CW)) dut0 (
        .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .oReady(oReady0),
        .iDataA(iDataA), .iDataB(iDataB), .iSigned(iSigned),
        .oValid(oValid0), .iReady(iReady), .oData(oData0), .iClear(iClear),
        .oCntGt(gt0), .oCntEq(eq0), .oCntLt(lt0)
    );

    stream_comparator #(.WIDTH(W), .SIGNED_EN(0), .CNT_W(CW)) dut1 (
        .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .oReady(oReady1),
        .iDataA(iDataA), .iDataB(iDataB), .iSigned(iSigned),
        .oValid(oValid1), .iReady(iReady), .oData(oData1), .iClear(iClear),
        .oCntGt(gt1), .oCntEq(eq1), .oCntLt(lt1)
    );

    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference result from integer values: operands reinterpreted as signed when the mode is effective.
    function automatic logic [2:0] expRes(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sgn, input int sen);
        int va;
        int vb;
        va = int'(a);
        vb = int'(b);
        if (sgn && sen != 0) begin
            if (va >= (1 << (W - 1))) va -= (1 << W);
            if (vb >= (1 << (W - 1))) vb -= (1 << W);
        end
        if (va > vb) return 3'b001;
        if (va == vb) return 3'b010;
        return 3'b100;
    endfunction

    task automatic checkDut(input int k, input logic rdy, input logic vld, input logic [2:0] dat,
                            input logic [CW-1:0] g, input logic [CW-1:0] e, input logic [CW-1:0] l,
                            input logic eVld, input logic eRdy);
        logic [2:0] eDat;
        eDat = 3'b000;
        if (eVld) eDat = expRes(fifo[0].a, fifo[0].b, fifo[0].sgn, (k == 0) ? 1 : 0);
        check($sformatf("d%0d_oReady", k), 64'(rdy), 64'(eRdy));
        check($sformatf("d%0d_oValid", k), 64'(vld), 64'(eVld));
        check($sformatf("d%0d_oData", k), 64'(dat), 64'(eDat));
        check($sformatf("d%0d_cntGt", k), 64'(g), 64'(mCnt[k][0]));
        check($sformatf("d%0d_cntEq", k), 64'(e), 64'(mCnt[k][1]));
        check($sformatf("d%0d_cntLt", k), 64'(l), 64'(mCnt[k][2]));
    endtask

    // Model: an accepted item is visible two cycles after its transfer once it reaches the head;
    // the block holds at most two items and accepts while below capacity or while delivering.
    always @(negedge iClk) begin
        logic       eVld;
        logic       eRdy;
        logic [2:0] r;
        int         idx;
        if (!iRstN) begin
            fifo.delete();
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 3; i++) mCnt[k][i] = 0;
            checkDut(0, oReady0, oValid0, oData0, gt0, eq0, lt0, 1'b0, 1'b0);
            checkDut(1, oReady1, oValid1, oData1, gt1, eq1, lt1, 1'b0, 1'b0);
        end else begin
            eVld = (fifo.size() > 0) && ((cyc - fifo[0].acc) >= 2);
            eRdy = (fifo.size() < 2) || iReady;
            checkDut(0, oReady0, oValid0, oData0, gt0, eq0, lt0, eVld, eRdy);
            checkDut(1, oReady1, oValid1, oData1, gt1, eq1, lt1, eVld, eRdy);
            if (eVld && iReady) begin
                for (int k = 0; k < 2; k++) begin
                    r   = expRes(fifo[0].a, fifo[0].b, fifo[0].sgn, (k == 0) ? 1 : 0);
                    idx = r[0] ? 0 : (r[1] ? 1 : 2);
                    if (!iClear && mCnt[k][idx] < CNTMAX) mCnt[k][idx]++;
                end
                void'(fifo.pop_front());
                nOut++;
            end
            if (iClear)
                for (int k = 0; k < 2; k++)
                    for (int i = 0; i < 3; i++) mCnt[k][i] = 0;
            if (iValid && eRdy) fifo.push_back('{a: iDataA, b: iDataB, sgn: iSigned, acc: cyc});
        end
    end

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        iDataA  = a;
        iDataB  = b;
        iSigned = s;
        iValid  = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion within budget");
        $fatal(1, "watchdog expired");
    end

    logic [W-1:0] stA[4];
    logic [W-1:0] stB[4];

    initial begin
        int   accepted;
        int   startOut;
        int   n;
        logic hs;

        // Reset state
        repeat (3) step();
        check("rst_oValid", 64'(oValid0), 64'd0);
        check("rst_oReady", 64'(oReady0), 64'd0);
        iRstN = 1'b1;
        #1;
        check("ready_after_release", 64'(oReady0), 64'd1);

        // Basic ordering and 2-cycle latency
        drive(8'd5, 8'd3, 1'b0);
        step();
        check("lat_c1_empty", 64'(oValid0), 64'd0);
        drive(8'd3, 8'd3, 1'b0);
        step();
        check("lat_c2_gt", 64'(oData0), 64'b001);
        drive(8'd3, 8'd5, 1'b0);
        step();
        check("lat_c3_eq", 64'(oData0), 64'b010);
        iValid = 1'b0;
        step();
        check("lat_c4_lt", 64'(oData0), 64'b100);
        step();
        check("basic_cntGt", 64'(gt0), 64'd1);
        check("basic_cntEq", 64'(eq0), 64'd1);
        check("basic_cntLt", 64'(lt0), 64'd1);

        // Signed vs unsigned interpretation of 0x80 vs 0x01
        drive(8'h80, 8'h01, 1'b1);
        step();
        drive(8'h80, 8'h01, 1'b0);
        step();
        iValid = 1'b0;
        check("sgn_en_signed", 64'(oData0), 64'b100);
        check("sgn_dis_signed", 64'(oData1), 64'b001);
        step();
        check("sgn_en_unsigned", 64'(oData0), 64'b001);
        check("sgn_dis_unsigned", 64'(oData1), 64'b001);
        repeat (2) step();

        // Backpressure: 4 back-to-back inputs with 5 stalled cycles
        stA = '{8'd1, 8'd2, 8'd3, 8'd0};
        stB = '{8'd2, 8'd2, 8'd2, 8'd0};
        startOut = nOut;
        accepted = 0;
        iReady   = 1'b0;
        drive(stA[0], stB[0], 1'b0);
        for (int t = 0; t < 5; t++) begin
            @(negedge iClk);
            hs = iValid && oReady0;
            step();
            if (hs) begin
                accepted++;
                if (accepted < 4) drive(stA[accepted], stB[accepted], 1'b0);
                else iValid = 1'b0;
            end
        end
        check("stall_accepted", 64'(accepted), 64'd2);
        check("stall_oReady", 64'(oReady0), 64'd0);
        check("stall_oValid", 64'(oValid0), 64'd1);
        check("stall_oData", 64'(oData0), 64'b100);
        iReady = 1'b1;
        for (int t = 0; t < 20 && accepted < 4; t++) begin
            @(negedge iClk);
            hs = iValid && oReady0;
            step();
            if (hs) begin
                accepted++;
                if (accepted < 4) drive(stA[accepted], stB[accepted], 1'b0);
                else iValid = 1'b0;
            end
        end
        iValid = 1'b0;
        repeat (4) step();
        check("stall_all_accepted", 64'(accepted), 64'd4);
        check("stall_delivered", 64'(nOut - startOut), 64'd4);

        // Saturation, then clear coincident with a delivery
        iClear = 1'b1;
        step();
        iClear = 1'b0;
        check("clear_cntGt", 64'(gt0), 64'd0);
        for (int i = 0; i < 17; i++) begin
            drive(8'd9, 8'd2, 1'b0);
            step();
        end
        iValid = 1'b0;
        repeat (3) step();
        check("sat_d0_cntGt", 64'(gt0), 64'd15);
        check("sat_d1_cntGt", 64'(gt1), 64'd15);
        drive(8'd4, 8'd4, 1'b0);
        step();
        iValid = 1'b0;
        n = 0;
        while (!oValid0 && n < 10) begin
            step();
            n++;
        end
        check("clr_eq_arrives", 64'(oData0), 64'b010);
        iClear = 1'b1;
        step();
        iClear = 1'b0;
        check("clr_win_cntGt", 64'(gt0), 64'd0);
        check("clr_win_cntEq", 64'(eq0), 64'd0);
        check("clr_win_cntLt", 64'(lt0), 64'd0);

        // Asynchronous reset with both stages full
        drive(8'd2, 8'd7, 1'b0);
        step();
        iValid = 1'b0;
        repeat (3) step();
        check("pre_rst_cntLt", 64'(lt0), 64'd1);
        iReady = 1'b0;
        drive(8'd1, 8'd1, 1'b0);
        step();
        drive(8'd6, 8'd0, 1'b0);
        step();
        iValid = 1'b0;
        check("full_oValid", 64'(oValid0), 64'd1);
        check("full_oReady", 64'(oReady0), 64'd0);
        #2;
        iRstN = 1'b0;
        #1;
        check("async_oValid", 64'(oValid0), 64'd0);
        check("async_oData", 64'(oData0), 64'd0);
        check("async_cntLt", 64'(lt0), 64'd0);
        check("async_d1_cntLt", 64'(lt1), 64'd0);
        check("async_oReady", 64'(oReady0), 64'd0);
        repeat (2) step();
        iReady = 1'b1;
        iRstN  = 1'b1;
        #1;
        check("rerelease_oReady", 64'(oReady0), 64'd1);
        drive(8'd7, 8'd7, 1'b0);
        step();
        iValid = 1'b0;
        step();
        check("after_rst_result", 64'(oData0), 64'b010);
        repeat (3) step();
        check("final_drained", 64'(fifo.size()), 64'd0);
        check("final_cntEq", 64'(eq0), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
